// File: rtl/fft_sequencer_if.sv
// fft_sequencer_if: control and handshake bundle between fft_sequencer and the FFT datapath
interface fft_sequencer_if #(parameter int N_MAX = 256);
   localparam int M_MAX = $clog2(N_MAX);
   localparam int LW = $clog2(M_MAX + 1);
   logic start;
   logic [LW-1:0] log2n;
   logic inverse;
   logic in_valid, in_ready, load_we;
   logic [M_MAX-1:0] load_adr, rd_adr_a, rd_adr_b, wr_adr_a, wr_adr_b, out_adr;
   logic rd_sel, we0, we1;
   logic [M_MAX-2:0] twiddle_adr;
   logic twiddle_conj, out_valid, out_ready, out_sel, out_last, busy, done, cfg_err;
   modport master (
      input start, log2n, inverse, in_valid, out_ready,
      output in_ready, load_we, load_adr, rd_adr_a, rd_adr_b, wr_adr_a, wr_adr_b, rd_sel, we0, we1,
             twiddle_adr, twiddle_conj, out_valid, out_adr, out_sel, out_last, busy, done, cfg_err
   );
   modport slave (
      output start, log2n, inverse, in_valid, out_ready,
      input in_ready, load_we, load_adr, rd_adr_a, rd_adr_b, wr_adr_a, wr_adr_b, rd_sel, we0, we1,
            twiddle_adr, twiddle_conj, out_valid, out_adr, out_sel, out_last, busy, done, cfg_err
   );
endinterface

// File: rtl/fft_sequencer.sv
// fft_sequencer: runtime-sized radix-2 ping-pong FFT control unit
module fft_sequencer #(
   parameter int N_MAX = 256,
   parameter int BFU_LAT = 2
) (
   input logic clk,
   input logic reset,
   fft_sequencer_if.master bus
);
   localparam int M_MAX = $clog2(N_MAX);
   localparam int LW = $clog2(M_MAX + 1);
   localparam int DW = $clog2(BFU_LAT + 1);
   localparam logic [DW-1:0] D_LAST = DW'(BFU_LAT - 1);
   localparam logic [LW-1:0] L_MAX = LW'(M_MAX);

   typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, OUTPUT} state_t;
   state_t state;
   logic [LW-1:0] l, lev;
   logic inv, done_q, cfg_err_q, issue;
   logic [M_MAX-1:0] cnt, n_m1, h_m1, rev, a0, b0, rd_a, rd_b;
   logic [M_MAX-2:0] tw;
   logic [DW-1:0] dcnt;
   logic [M_MAX:0] n_full;
   logic [2*M_MAX-1:0] rot_a, rot_b;
   logic pv [BFU_LAT];
   logic ps [BFU_LAT];
   logic [M_MAX-1:0] pa [BFU_LAT];
   logic [M_MAX-1:0] pb [BFU_LAT];

   // cnt serves as in_cnt, butterfly index and out_idx depending on state
   always_comb begin
      n_full = (M_MAX+1)'(1) << l;
      n_m1 = M_MAX'(n_full - 1'b1);
      h_m1 = M_MAX'((n_full >> 1) - 1'b1);
      issue = state == COMPUTE;
      a0 = {cnt[M_MAX-2:0], 1'b0};
      b0 = {cnt[M_MAX-2:0], 1'b1};
      rot_a = (2*M_MAX)'(a0) << lev;
      rot_b = (2*M_MAX)'(b0) << lev;
      rd_a = (rot_a[M_MAX-1:0] | M_MAX'(rot_a >> l)) & n_m1;
      rd_b = (rot_b[M_MAX-1:0] | M_MAX'(rot_b >> l)) & n_m1;
      rev = '0;
      for (int i = 0; i < M_MAX; i++) rev[i] = cnt[M_MAX-1-i];
      tw = (M_MAX-1)'((cnt & ~M_MAX'((n_full >> (lev + 1'b1)) - 1'b1)) << (M_MAX - l));
   end

   assign bus.in_ready = state == LOAD;
   assign bus.load_we = state == LOAD && bus.in_valid;
   assign bus.load_adr = state == LOAD ? rev >> (M_MAX - l) : '0;
   assign bus.rd_adr_a = issue ? rd_a : '0;
   assign bus.rd_adr_b = issue ? rd_b : '0;
   assign bus.rd_sel = issue & lev[0];
   assign bus.twiddle_adr = issue ? tw : '0;
   assign bus.twiddle_conj = inv;
   assign bus.wr_adr_a = pa[BFU_LAT-1];
   assign bus.wr_adr_b = pb[BFU_LAT-1];
   assign bus.we0 = pv[BFU_LAT-1] & ps[BFU_LAT-1];
   assign bus.we1 = pv[BFU_LAT-1] & ~ps[BFU_LAT-1];
   assign bus.out_valid = state == OUTPUT;
   assign bus.out_adr = state == OUTPUT ? cnt : '0;
   assign bus.out_sel = l[0];
   assign bus.out_last = state == OUTPUT && cnt == n_m1;
   assign bus.busy = state != IDLE;
   assign bus.done = done_q;
   assign bus.cfg_err = cfg_err_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         l <= '0;
         lev <= '0;
         inv <= 1'b0;
         cnt <= '0;
         dcnt <= '0;
         done_q <= 1'b0;
         cfg_err_q <= 1'b0;
         for (int i = 0; i < BFU_LAT; i++) begin
            pv[i] <= 1'b0;
            ps[i] <= 1'b0;
            pa[i] <= '0;
            pb[i] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         cfg_err_q <= 1'b0;
         pv[0] <= issue;
         ps[0] <= issue & lev[0];
         pa[0] <= issue ? rd_a : '0;
         pb[0] <= issue ? rd_b : '0;
         for (int i = 1; i < BFU_LAT; i++) begin
            pv[i] <= pv[i-1];
            ps[i] <= ps[i-1];
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
         end
         case (state)
            IDLE: if (bus.start) begin
               if (bus.log2n != '0 && bus.log2n <= L_MAX) begin
                  l <= bus.log2n;
                  inv <= bus.inverse;
                  cnt <= '0;
                  lev <= '0;
                  dcnt <= '0;
                  state <= LOAD;
               end else cfg_err_q <= 1'b1;
            end
            LOAD: if (bus.in_valid) begin
               cnt <= cnt == n_m1 ? '0 : cnt + 1'b1;
               state <= cnt == n_m1 ? COMPUTE : LOAD;
            end
            COMPUTE: begin
               cnt <= cnt == h_m1 ? '0 : cnt + 1'b1;
               state <= cnt == h_m1 ? DRAIN : COMPUTE;
            end
            // hold off the next level until every write of this one has landed
            DRAIN: if (dcnt == D_LAST) begin
               dcnt <= '0;
               lev <= lev == l - 1'b1 ? lev : lev + 1'b1;
               state <= lev == l - 1'b1 ? OUTPUT : COMPUTE;
            end else dcnt <= dcnt + 1'b1;
            OUTPUT: if (bus.out_ready) begin
               cnt <= cnt == n_m1 ? '0 : cnt + 1'b1;
               state <= cnt == n_m1 ? IDLE : OUTPUT;
               done_q <= cnt == n_m1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fft_sequencer.sv
// tb_fft_sequencer: directed, table-driven bench for fft_sequencer
module tb_fft_sequencer;
   localparam int N_MAX = 256;
   localparam int BFU_LAT = 2;
   typedef struct { int lev; int idx; int ra; int rb; int tw; int sel; } avec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   int adrq[$];
   int cyc;
   int n0, n1, nb, nc, nov, nbusy, ntw0;
   int r_ra[41], r_rb[41], r_tw[41], r_sel[41], r_we0[41], r_we1[41];
   int r_wa[41], r_wb[41], r_conj[41], r_ov[41], r_busy[41], r_osel[41];
   avec_t av[9];
   int rev3[8];
   int rej[3];
   logic [66:0] all_out;

   always #5 clk = ~clk;

   fft_sequencer_if #(.N_MAX(N_MAX)) bus ();
   fft_sequencer #(.N_MAX(N_MAX), .BFU_LAT(BFU_LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

   assign all_out = {bus.in_ready, bus.load_we, bus.load_adr, bus.rd_adr_a, bus.rd_adr_b,
                     bus.wr_adr_a, bus.wr_adr_b, bus.rd_sel, bus.we0, bus.we1, bus.twiddle_adr,
                     bus.twiddle_conj, bus.out_valid, bus.out_adr, bus.out_sel, bus.out_last,
                     bus.busy, bus.done, bus.cfg_err};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int l2, input bit inv);
      bus.start = 1'b1;
      bus.log2n = 4'(l2);
      bus.inverse = inv;
      step;
      bus.start = 1'b0;
   endtask

   task automatic load(input int n, input bit gaps);
      int k = 0;
      adrq.delete();
      for (int g = 0; g < 4 * n + 8 && k < n; g++) begin
         bus.in_valid = !gaps || g % 2 == 0;
         #4;
         chk("in_ready", bus.in_ready, 1);
         chk("load_we", bus.load_we, bus.in_valid);
         if (bus.in_valid) begin
            adrq.push_back(int'(bus.load_adr));
            k++;
         end
         step;
      end
      bus.in_valid = 1'b0;
      chk("load_count", k, n);
   endtask

   task automatic wait_ov(input int maxc, output int c_out);
      c_out = -1;
      for (int c = 0; c < maxc; c++) begin
         #4;
         if (bus.out_valid && c_out < 0) c_out = c;
         step;
         if (c_out >= 0) break;
      end
   endtask

   task automatic drain(input int n, input bit toggle, input int nxt);
      int idx = 0;
      for (int c = 0; c < 4 * n + 8 && idx < n; c++) begin
         bus.out_ready = !toggle || c % 2 == 1;
         #4;
         chk("out_valid", bus.out_valid, 1);
         chk("out_adr", bus.out_adr, idx);
         chk("out_last", bus.out_last, idx == n - 1);
         chk("done_early", bus.done, 0);
         if (bus.out_ready) idx++;
         step;
      end
      bus.out_ready = 1'b0;
      if (nxt > 0) begin
         bus.start = 1'b1;
         bus.log2n = 4'(nxt);
         bus.inverse = 1'b0;
      end
      #4;
      chk("done_pulse", bus.done, 1);
      chk("busy_at_done", bus.busy, 0);
      chk("out_valid_at_done", bus.out_valid, 0);
      step;
      bus.start = 1'b0;
      #4;
      chk("done_once", bus.done, 0);
      chk("busy_after_done", bus.busy, nxt > 0);
      step;
   endtask

   initial begin
      av[0] = '{0, 0, 0, 1, 0, 0};
      av[1] = '{0, 3, 6, 7, 0, 0};
      av[2] = '{0, 7, 14, 15, 0, 0};
      av[3] = '{1, 1, 4, 6, 0, 1};
      av[4] = '{1, 5, 5, 7, 64, 1};
      av[5] = '{2, 3, 9, 13, 32, 0};
      av[6] = '{2, 6, 3, 7, 96, 0};
      av[7] = '{3, 2, 2, 10, 32, 1};
      av[8] = '{3, 7, 7, 15, 112, 1};
      rev3 = '{0, 4, 2, 6, 1, 5, 3, 7};
      rej = '{0, 9, 15};
      bus.start = 1'b0;
      bus.log2n = '0;
      bus.inverse = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;

      step;
      step;
      #4;
      chk("reset_all_zero", |all_out, 0);
      step;
      reset = 1'b0;
      #4;
      chk("idle_all_zero", |all_out, 0);
      step;

      for (int i = 0; i < 3; i++) begin
         do_start(rej[i], 1'b0);
         #4;
         chk("cfg_err", bus.cfg_err, 1);
         chk("rejected_busy", bus.busy, 0);
         step;
         #4;
         chk("cfg_err_pulse", bus.cfg_err, 0);
         step;
      end

      // bit-reversed load with gaps, start while busy ignored
      do_start(3, 1'b0);
      #4;
      chk("start_busy", bus.busy, 1);
      chk("start_in_ready", bus.in_ready, 1);
      chk("start_cfg_err", bus.cfg_err, 0);
      step;
      bus.start = 1'b1;
      bus.log2n = 4'd5;
      step;
      bus.start = 1'b0;
      #4;
      chk("busy_start_cfg_err", bus.cfg_err, 0);
      step;
      load(8, 1'b1);
      #4;
      chk("in_ready_drop", bus.in_ready, 0);
      step;
      for (int i = 0; i < 8; i++) chk("load_adr_l3", i < adrq.size() ? adrq[i] : -1, rev3[i]);
      wait_ov(40, cyc);
      chk("l3_latency", cyc, 17);
      chk("l3_out_sel", bus.out_sel, 1);
      drain(8, 1'b0, 0);

      // addresses, twiddles, ping-pong timing for log2n=4, inverse
      do_start(4, 1'b1);
      #4;
      chk("l4_busy", bus.busy, 1);
      step;
      load(16, 1'b0);
      for (int c = 0; c <= 40; c++) begin
         #4;
         r_ra[c] = int'(bus.rd_adr_a);
         r_rb[c] = int'(bus.rd_adr_b);
         r_tw[c] = int'(bus.twiddle_adr);
         r_sel[c] = int'(bus.rd_sel);
         r_we0[c] = int'(bus.we0);
         r_we1[c] = int'(bus.we1);
         r_wa[c] = int'(bus.wr_adr_a);
         r_wb[c] = int'(bus.wr_adr_b);
         r_conj[c] = int'(bus.twiddle_conj);
         r_ov[c] = int'(bus.out_valid);
         r_busy[c] = int'(bus.busy);
         r_osel[c] = int'(bus.out_sel);
         step;
      end
      for (int i = 0; i < 9; i++) begin
         chk("rd_adr_a", r_ra[av[i].lev * 10 + av[i].idx], av[i].ra);
         chk("rd_adr_b", r_rb[av[i].lev * 10 + av[i].idx], av[i].rb);
         chk("twiddle_adr", r_tw[av[i].lev * 10 + av[i].idx], av[i].tw);
         chk("rd_sel", r_sel[av[i].lev * 10 + av[i].idx], av[i].sel);
      end
      n0 = 0; n1 = 0; nb = 0; nc = 0; nov = 0; nbusy = 0; ntw0 = 0;
      for (int c = 0; c < 40; c++) begin
         n0 += r_we0[c];
         n1 += r_we1[c];
         nb += r_we0[c] & r_we1[c];
         nc += r_conj[c];
         nov += r_ov[c];
         nbusy += r_busy[c];
         if (c < 8 && r_tw[c] != 0) ntw0++;
      end
      chk("we0_count", n0, 16);
      chk("we1_count", n1, 16);
      chk("we_both_high", nb, 0);
      chk("twiddle_conj_cycles", nc, 40);
      chk("out_valid_before_40", nov, 0);
      chk("out_valid_at_40", r_ov[40], 1);
      chk("busy_cycles", nbusy, 40);
      chk("tw_level0_zero", ntw0, 0);
      chk("we1_c1", r_we1[1], 0);
      chk("we1_c2", r_we1[2], 1);
      chk("wr_a_c2", r_wa[2], 0);
      chk("wr_b_c2", r_wb[2], 1);
      chk("we1_c10", r_we1[10], 0);
      chk("we0_c17", r_we0[17], 1);
      chk("wr_a_c17", r_wa[17], 5);
      chk("wr_b_c17", r_wb[17], 7);
      chk("we0_last", r_we0[39], 1);
      chk("l4_out_sel", r_osel[40], 0);
      drain(16, 1'b0, 0);

      // backpressure on log2n=5, back-to-back start of log2n=3
      do_start(5, 1'b0);
      #4;
      chk("l5_busy", bus.busy, 1);
      chk("l5_conj", bus.twiddle_conj, 0);
      step;
      load(32, 1'b0);
      wait_ov(120, cyc);
      chk("l5_latency", cyc, 90);
      drain(32, 1'b1, 3);

      // reset during level 2 of the log2n=3 run
      load(8, 1'b0);
      for (int c = 0; c < 13; c++) step;
      reset = 1'b1;
      #4;
      chk("pre_reset_busy", bus.busy, 1);
      chk("pre_reset_rd_a", bus.rd_adr_a, 1);
      chk("pre_reset_rd_b", bus.rd_adr_b, 5);
      step;
      reset = 1'b0;
      #4;
      chk("post_reset_zero", |all_out, 0);
      step;
      #4;
      chk("no_stray_write", |all_out, 0);
      step;

      do_start(1, 1'b0);
      #4;
      chk("l1_busy", bus.busy, 1);
      step;
      load(2, 1'b0);
      chk("l1_adr0", adrq.size() > 0 ? adrq[0] : -1, 0);
      chk("l1_adr1", adrq.size() > 1 ? adrq[1] : -1, 1);
      wait_ov(20, cyc);
      chk("l1_latency", cyc, 3);
      chk("l1_out_sel", bus.out_sel, 1);
      drain(2, 1'b0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fft_sequencer.md
# fft_sequencer

Runtime-configurable control unit for the in-place radix-2 ping-pong FFT processor. Sequences a full transform from sample ingest (bit-reversed load into RAM0), through log2n butterfly levels with a pipelined BFU, to an ordered read-out stream. It sits between the sample front end, the two ping-pong RAMs, the twiddle ROM and the pitch-detection back end. Unlike the fixed-size control unit, it supports:
- transform size chosen per run,
- forward/inverse mode,
- valid/ready handshakes,
- BFU pipeline latency hazards.

## Interface
- N_MAX, 256, largest supported transform size (power of two, ≥4); M_MAX = $clog2(N_MAX), LW = $clog2(M_MAX+1)
- BFU_LAT, 2, BFU read-to-write latency in cycles (≥1)
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- start  in  1  begin a run; sampled only in IDLE
- log2n  in  LW  transform size exponent (valid 1..M_MAX), captured at start
- inverse  in  1  inverse-transform mode, captured at start
- in_valid / in_ready  in / out  1  sample ingest handshake
- load_we  out  1  RAM0 write strobe for ingest
- load_adr  out  M_MAX  bit-reversed ingest address
- rd_adr_a, rd_adr_b  out  M_MAX  butterfly read addresses
- wr_adr_a, wr_adr_b  out  M_MAX  butterfly write addresses, delayed BFU_LAT
- rd_sel  out  1  0: read RAM0, 1: read RAM1
- we0, we1  out  1  butterfly write strobes for RAM0 / RAM1
- twiddle_adr  out  M_MAX-1  index into N_MAX/2-entry twiddle ROM
- twiddle_conj  out  1  conjugate twiddle (= captured inverse)
- out_valid / out_ready  out / in  1  result stream handshake
- out_adr  out  M_MAX  result read address (natural order)
- out_sel  out  1  RAM holding results (= log2n[0])
- out_last  out  1  marks final result
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse at end of run
- cfg_err  out  1  one-cycle pulse on rejected start

## Operation
- States: IDLE → LOAD → COMPUTE → DRAIN ↔ COMPUTE → OUTPUT → IDLE. Let L = captured log2n and n = 2^L.
- **IDLE:**
  - When start=1 and 1≤log2n≤M_MAX: capture log2n/inverse and go to LOAD.
  - Otherwise, start=1 pulses cfg_err and the state stays IDLE.
  - start outside IDLE is ignored.
- **LOAD:**
  - in_ready=1; load_we = in_valid & in_ready.
  - load_adr = low L bits of in_cnt reversed; upper bits are 0.
  - in_cnt increments on each accepted sample; the n-th accept moves to COMPUTE.
- **COMPUTE:**
  - Issues one butterfly per cycle: index 0..n/2−1 at the current level 0..L−1.
  - A = 2·index and B = A+1, each rotated left by level within L bits; upper bits are 0.
  - rd_sel = level[0].
  - twiddle_adr = (index with its low L−1−level bits cleared) << (M_MAX−L).
  - After the last index of a level, go to DRAIN.
- **Write path:** a BFU_LAT-deep delay line carries {valid, rd_sel, adr_A, adr_B}.
  - On delayed valid: wr_adr_a/b = the delayed addresses.
  - we1 = ~delayed rd_sel; we0 = delayed rd_sel.
- **DRAIN:**
  - No issue for BFU_LAT cycles, so the level's writes complete before the next level reads (RAW hazard).
  - Then level+1 → COMPUTE, or after level L−1 → OUTPUT.
- **OUTPUT:**
  - out_valid=1; out_adr = out_idx; out_last = (out_idx == n−1).
  - out_idx advances on out_valid & out_ready.
  - The last handshake pulses done and returns to IDLE.
  - The consumer reads the RAM selected by out_sel at out_adr.

## Timing
- **Reset:** state IDLE, all counters 0. Every output is 0, including in_ready, out_valid, busy, done, cfg_err, we0, we1, load_we.
- **Reset mid-run:** takes effect next edge, from any state. Pending delay-line writes are discarded, so no we0/we1 follows reset.
- **Start:** accepted at edge t. busy=1 and in_ready=1 from t+1.
- **Load:** one sample per cycle max; an in_valid gap stalls in_cnt only.
- **COMPUTE + DRAIN:** exactly L·(n/2 + BFU_LAT) cycles, independent of the handshakes. Writes for a read issued at cycle c occur at cycle c+BFU_LAT.
- **Level boundaries:** we0 and we1 are never both high. No read issues while a write to the same RAM is pending.
- **Output:** out_valid rises the cycle after the final DRAIN cycle. It holds with stable out_adr while out_ready=0.
- **done:** asserts the cycle after the last output handshake, together with busy=0. A start in that same cycle is accepted (back-to-back runs).
- **Arithmetic:** in_cnt, index and out_idx are M_MAX-bit unsigned counters compared against the runtime bounds. No wrap-around occurs past n.

## Test plan
- **Bit-reversed load:** log2n=3, 8 samples with in_valid gaps.
  - load_adr sequence must be 0,4,2,6,1,5,3,7.
  - in_ready must drop after the 8th accept.
- **Addresses and twiddles:** log2n=4, N_MAX=256.
  - Level 1, index 1: rd_adr_a=4, rd_adr_b=6.
  - Level 1, index 5: twiddle_adr=64.
  - Level 0: twiddle_adr=0 throughout.
- **Pipeline and ping-pong:** log2n=4, BFU_LAT=2.
  - COMPUTE+DRAIN lasts 40 cycles.
  - Level 0 writes appear on we1 two cycles after the reads; the last level writes we0.
  - out_sel=0.
- **Output backpressure:** log2n=5.
  - Toggling out_ready holds out_adr stable.
  - out_last is high only at out_adr=31.
  - done pulses once, then the block is IDLE.
- **Rejected configs and mode:**
  - start with log2n=0 or M_MAX+1 pulses cfg_err and stays IDLE.
  - start with inverse=1 gives twiddle_conj=1 through COMPUTE.
  - start while busy is ignored.
- **Reset mid-run:** reset during COMPUTE level 2 (with writes pending) forces every output to 0 next cycle, with no stray we0/we1. A subsequent start runs normally.
